// File: rtl/rv32i_pkg.sv
// Constants shared by the RV32I front-end blocks.
package rv32i_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [ILEN-1:0] NOP    = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous instruction buffer with flush; head entry is read straight from storage registers.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    // a push into a full buffer is only legal when the head leaves the same cycle
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_d    = do_pop  ? nxt(rd_q) : rd_q;
    wr_d    = do_push ? nxt(wr_q) : wr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CW'(1);
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem_q[wr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the PC, keeps several reads in flight, buffers words for decode.
module fetch_queue #(
  parameter int unsigned     XLEN       = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_raddr,
  input  logic            i_mem_rsp_valid,
  input  logic [31:0]     i_mem_rsp_data,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_inst_pc
);

  import rv32i_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = XLEN + ILEN;

  logic [XLEN-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CW:0]     inflight;
  logic            req_fire, rsp_fire, push, pop, fifo_valid;
  logic [FW-1:0]   fifo_rdata;

  // words in the buffer plus words still owed by memory can never exceed the buffer size
  assign inflight        = {1'b0, out_q} + {1'b0, fifo_count};
  assign o_mem_req_valid = !rst && (inflight < (CW+1)'(FIFO_DEPTH));
  assign o_mem_raddr     = req_pc_q;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;
  assign rsp_fire        = i_mem_rsp_valid && (out_q != '0);
  assign redir_pc        = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign push            = rsp_fire && (drop_q == '0) && !i_redirect_valid;
  assign pop             = o_inst_valid && i_inst_ready;

  always_comb begin
    out_d = out_q;
    if (req_fire && !rsp_fire)
      out_d = out_q + CW'(1);
    else if (!req_fire && rsp_fire)
      out_d = out_q - CW'(1);

    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    if (i_redirect_valid) begin
      req_pc_d = redir_pc;
      rsp_pc_d = redir_pc;
      drop_d   = out_d;
    end else begin
      if (req_fire)
        req_pc_d = req_pc_q + XLEN'(INST_BYTES);
      if (rsp_fire) begin
        if (drop_q != '0)
          drop_d = drop_q - CW'(1);
        else
          rsp_pc_d = rsp_pc_q + XLEN'(INST_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q <= RESET_ADDR;
      rsp_pc_q <= RESET_ADDR;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({rsp_pc_q, i_mem_rsp_data}),
    .pop_i   (pop),
    .flush_i (i_redirect_valid),
    .valid_o (fifo_valid),
    .data_o  (fifo_rdata),
    .count_o (fifo_count)
  );

  assign o_inst_valid = fifo_valid && !rst;
  assign o_inst       = o_inst_valid ? fifo_rdata[ILEN-1:0]  : '0;
  assign o_inst_pc    = o_inst_valid ? fifo_rdata[FW-1:ILEN] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for streaming/backpressure, hand sequences for redirect and reset.
module tb_fetch_queue;

  logic        clk, rst, redir_v, req_v, req_rdy, rsp_v, inst_v, inst_rdy;
  logic [31:0] redir_pc, raddr, rsp_data, inst, inst_pc;
  logic        rst5, req_rdy5, req_v5, inst_v5;
  logic [31:0] raddr5, inst5, inst_pc5;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic        rsp_en;
  logic [31:0] pend[$];

  typedef struct {
    logic        rst, rr, ir, rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t vq[$];

  fetch_queue #(.XLEN(32), .RESET_ADDR(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_redirect_valid(redir_v), .i_redirect_pc(redir_pc),
    .o_mem_req_valid(req_v), .i_mem_req_ready(req_rdy), .o_mem_raddr(raddr),
    .i_mem_rsp_valid(rsp_v), .i_mem_rsp_data(rsp_data),
    .o_inst_valid(inst_v), .i_inst_ready(inst_rdy), .o_inst(inst), .o_inst_pc(inst_pc));

  fetch_queue #(.XLEN(32), .RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut5 (
    .clk(clk), .rst(rst5), .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
    .o_mem_req_valid(req_v5), .i_mem_req_ready(req_rdy5), .o_mem_raddr(raddr5),
    .i_mem_rsp_valid(1'b0), .i_mem_rsp_data(32'h0),
    .o_inst_valid(inst_v5), .i_inst_ready(1'b1), .o_inst(inst5), .o_inst_pc(inst_pc5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // memory model: in-order, one response per cycle, data = ~address
  task automatic settle();
    if (rsp_en) begin
      rsp_v    = (pend.size() > 0);
      rsp_data = rsp_v ? ~pend[0] : 32'h0;
    end
    #1;
  endtask

  task automatic advance();
    if (rst) pend.delete();
    else begin
      if (rsp_v && pend.size() > 0) void'(pend.pop_front());
      if (req_v && req_rdy) pend.push_back(raddr);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; redir_v = 1'b0; redir_pc = 32'h0; rsp_en = 1'b1; rsp_v = 1'b0;
    rsp_data = 32'h0; req_rdy = 1'b1; inst_rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic add(input logic r, input logic rr, input logic ir, input logic rv,
                     input logic [31:0] ra, input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.rst = r; v.rr = rr; v.ir = ir; v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc;
    vq.push_back(v);
  endtask

  task automatic chk_inst(input string name, input logic [31:0] pc);
    chk({name, ".iv"}, {31'b0, inst_v}, 32'h1);
    chk({name, ".pc"}, inst_pc, pc);
    chk({name, ".inst"}, inst, ~pc);
  endtask

  initial begin
    logic [31:0] exp5 [4];
    rst5 = 1'b1; req_rdy5 = 1'b1;
    rst = 1'b1; redir_v = 1'b0; redir_pc = 32'h0; rsp_en = 1'b1; rsp_v = 1'b0;
    rsp_data = 32'h0; req_rdy = 1'b1; inst_rdy = 1'b1;
    @(negedge clk);
    step();

    // streaming with 1-cycle memory, then decode stall filling the buffer
    //  rst   rr    ir    rv    raddr         iv    inst_pc
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14);
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; req_rdy = vq[i].rr; inst_rdy = vq[i].ir;
      settle();
      chk($sformatf("tbl%0d.rv", i), {31'b0, req_v}, {31'b0, vq[i].rv});
      chk($sformatf("tbl%0d.raddr", i), raddr, vq[i].ra);
      chk($sformatf("tbl%0d.iv", i), {31'b0, inst_v}, {31'b0, vq[i].iv});
      chk($sformatf("tbl%0d.pc", i), inst_pc, vq[i].ipc);
      chk($sformatf("tbl%0d.inst", i), inst, vq[i].iv ? ~vq[i].ipc : 32'h0);
      advance();
    end

    // three in flight, redirect to an unaligned target
    do_reset();
    rsp_en = 1'b0; rsp_v = 1'b0;
    repeat (3) step();
    redir_v = 1'b1; redir_pc = 32'h103; req_rdy = 1'b0;
    step();
    redir_v = 1'b0; req_rdy = 1'b1;
    settle();
    chk("rdr.rv", {31'b0, req_v}, 32'h1);
    chk("rdr.raddr", raddr, 32'h100);
    advance();
    rsp_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("rdr.drop%0d.iv", k), {31'b0, inst_v}, 32'h0);
      advance();
    end
    settle(); chk_inst("rdr.first", 32'h100); advance();
    settle(); chk_inst("rdr.second", 32'h104); advance();

    // redirect coinciding with a response and an accepted request
    do_reset();
    rsp_en = 1'b0; rsp_v = 1'b0;
    step();
    step();
    rsp_en = 1'b1; redir_v = 1'b1; redir_pc = 32'h200;
    settle();
    chk("co.rv", {31'b0, req_v}, 32'h1);
    chk("co.raddr", raddr, 32'h08);
    advance();
    redir_v = 1'b0;
    settle();
    chk("co.next.raddr", raddr, 32'h200);
    chk("co.next.iv", {31'b0, inst_v}, 32'h0);
    advance();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("co.drop%0d.iv", k), {31'b0, inst_v}, 32'h0);
      advance();
    end
    settle(); chk_inst("co.first", 32'h200); advance();
    // redirect while the head is being popped: the pop is discarded with the flush
    redir_v = 1'b1; redir_pc = 32'h300;
    settle(); chk_inst("fl.head", 32'h204); advance();
    redir_v = 1'b0;
    settle();
    chk("fl.iv", {31'b0, inst_v}, 32'h0);
    chk("fl.raddr", raddr, 32'h300);
    advance();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("fl.drop%0d.iv", k), {31'b0, inst_v}, 32'h0);
      advance();
    end
    settle(); chk_inst("fl.first", 32'h300); advance();

    // reset with two outstanding and two queued, stale responses afterwards
    do_reset();
    inst_rdy = 1'b0;
    repeat (3) step();
    rsp_en = 1'b0; rsp_v = 1'b0;
    settle();
    chk_inst("rst.pre", 32'h0);
    chk("rst.pre.raddr", raddr, 32'h0C);
    advance();
    rst = 1'b1;
    settle();
    chk("rst.during.rv", {31'b0, req_v}, 32'h0);
    chk("rst.during.iv", {31'b0, inst_v}, 32'h0);
    advance();
    settle();
    chk("rst.after.rv", {31'b0, req_v}, 32'h0);
    chk("rst.after.raddr", raddr, 32'h0);
    chk("rst.after.iv", {31'b0, inst_v}, 32'h0);
    chk("rst.after.inst", inst, 32'h0);
    chk("rst.after.pc", inst_pc, 32'h0);
    advance();
    rst = 1'b0; req_rdy = 1'b0; rsp_v = 1'b1; rsp_data = 32'hDEAD_BEEF;
    settle();
    chk("stale0.rv", {31'b0, req_v}, 32'h1);
    chk("stale0.iv", {31'b0, inst_v}, 32'h0);
    advance();
    settle(); chk("stale1.iv", {31'b0, inst_v}, 32'h0); advance();
    rsp_v = 1'b0;
    settle(); chk("stale2.iv", {31'b0, inst_v}, 32'h0); advance();
    rsp_en = 1'b1; req_rdy = 1'b1; inst_rdy = 1'b1;
    settle();
    chk("post.rv", {31'b0, req_v}, 32'h1);
    chk("post.raddr", raddr, 32'h0);
    chk("post.iv", {31'b0, inst_v}, 32'h0);
    advance();
    step();
    settle(); chk_inst("post.first", 32'h0); advance();

    // PC wrap from a high reset address
    exp5[0] = 32'hFFFF_FFF8; exp5[1] = 32'hFFFF_FFFC; exp5[2] = 32'h0000_0000; exp5[3] = 32'h0000_0004;
    @(negedge clk);
    rst5 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wrap%0d.rv", k), {31'b0, req_v5}, 32'h1);
      chk($sformatf("wrap%0d.raddr", k), raddr5, exp5[k]);
      @(negedge clk);
    end
    #1;
    chk("wrap.rv.full", {31'b0, req_v5}, 32'h0);
    chk("wrap.iv", {31'b0, inst_v5}, 32'h0);
    chk("wrap.inst", inst5, 32'h0);
    chk("wrap.pc", inst_pc5, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
